// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronises and de-glitches the PS/2 pins,
// deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop) and
// reports each frame with exactly one status pulse.
module ps2_rx #(
  parameter int unsigned FREQ       = 25,
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned TIMEOUT_US = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int unsigned LIMIT = FREQ * TIMEOUT_US;
  localparam int unsigned TW    = $clog2(LIMIT + 1);
  localparam int unsigned FW    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  logic          clk_s1_q, clk_s2_q;
  logic          dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall_c;

  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          timeout_c;
  logic [7:0]    data_q, data_d;
  logic          data_valid_q, data_valid_d;
  logic          parity_err_q, parity_err_d;
  logic          frame_err_q, frame_err_d;

  // Two-flop synchronisers for both pins; idle-high reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Filter: flip the clean clock after FILTER_LEN consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    fall_c = 1'b0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = ~filt_q;
        fall_c = filt_q;
      end else begin
        fcnt_d = FW'(fcnt_q + FW'(1));
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q       <= 1'b1;
      fcnt_q       <= '0;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      filt_q       <= filt_d;
      fcnt_q       <= fcnt_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      tmo_q        <= tmo_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Frame FSM, inter-edge timeout and status decision.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;

    // A falling edge in the same cycle always beats the timeout.
    timeout_c = (state_q != IDLE) && !fall_c && (tmo_q == TW'(LIMIT - 1));
    if ((state_q == IDLE) || fall_c || timeout_c) begin
      tmo_d = '0;
    end else begin
      tmo_d = TW'(tmo_q + TW'(1));
    end

    case (state_q)
      IDLE: begin
        if (fall_c && !dat_s2_q) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (fall_c) begin
          shift_d = {dat_s2_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end else begin
            bit_cnt_d = 3'(bit_cnt_q + 3'd1);
          end
        end
      end
      PARITY: begin
        if (fall_c) begin
          par_d   = dat_s2_q;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall_c) begin
          state_d = IDLE;
          if (!dat_s2_q) begin
            frame_err_d = 1'b1;
          end else if (^{shift_q, par_q} != 1'b1) begin
            parity_err_d = 1'b1;
          end else begin
            data_valid_d = 1'b1;
            data_d       = shift_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout_c) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: directed and random PS/2 frames against a frame-level model.
module tb_ps2_rx;

  localparam int unsigned FREQ       = 25;
  localparam int unsigned FILTER_LEN = 4;
  localparam int unsigned TIMEOUT_US = 200;
  localparam int unsigned LIMIT      = FREQ * TIMEOUT_US;

  logic       clk;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] data;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;

  ps2_rx #(
    .FREQ      (FREQ),
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT_US(TIMEOUT_US)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .data      (data),
    .data_valid(data_valid),
    .parity_err(parity_err),
    .frame_err (frame_err)
  );

  // 25 MHz system clock.
  initial clk = 1'b0;
  always #20 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Monitor: cycle counter, pulse counters, log of received bytes.
  int         cyc    = 0;
  int         n_dv   = 0;
  int         n_pe   = 0;
  int         n_fe   = 0;
  int         n_multi = 0;
  int         fe_cyc = 0;
  logic [7:0] dv_log [0:63];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid) begin
      dv_log[n_dv % 64] <= data;
      n_dv <= n_dv + 1;
    end
    if (parity_err) n_pe <= n_pe + 1;
    if (frame_err) begin
      n_fe   <= n_fe + 1;
      fe_cyc <= cyc;
    end
    if ((int'(data_valid) + int'(parity_err) + int'(frame_err)) > 1) n_multi <= n_multi + 1;
  end

  int         s_dv = 0, s_pe = 0, s_fe = 0;
  int         t_fall = 0;
  logic [7:0] exp_data = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive the first nbits of a frame (bit 0 = start), one bit per ps2 clock period.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input int half);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      wait_cyc(half);
      ps2_clk = 1'b0;
      t_fall  = cyc;
      wait_cyc(half);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic par, input logic stop);
    return {stop, par, b, 1'b0};
  endfunction

  // Compare pulse counts since the previous call and the data output.
  task automatic expect_frame(input string tag, input int edv, input int epe, input int efe);
    chk({tag, "_dv"}, 32'(n_dv - s_dv), 32'(edv));
    chk({tag, "_pe"}, 32'(n_pe - s_pe), 32'(epe));
    chk({tag, "_fe"}, 32'(n_fe - s_fe), 32'(efe));
    chk({tag, "_data"}, {24'h0, data}, {24'h0, exp_data});
    s_dv = n_dv;
    s_pe = n_pe;
    s_fe = n_fe;
  endtask

  logic [7:0] rb;
  logic       rpar, rstop;
  int         ones, edv, epe, efe;

  initial begin
    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(5);
    chk("rst_data", {24'h0, data}, 32'h0);
    chk("rst_dv", {31'h0, data_valid}, 32'h0);
    chk("rst_pe", {31'h0, parity_err}, 32'h0);
    chk("rst_fe", {31'h0, frame_err}, 32'h0);
    rst_n = 1'b1;
    wait_cyc(10);

    // Good 0x1C frame at a 10 us bit period.
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11, 125);
    wait_cyc(300);
    exp_data = 8'h1C;
    expect_frame("good_1c", 1, 0, 0);

    // Wrong parity: parity_err only, data held.
    send_bits(mk_frame(8'h1C, 1'b1, 1'b1), 11, 125);
    wait_cyc(300);
    expect_frame("par_1c", 0, 1, 0);

    // Start plus 5 data bits then silence: timeout frame_err.
    send_bits(mk_frame(8'h15, 1'b0, 1'b1), 6, 125);
    wait_cyc(LIMIT + 200);
    expect_frame("timeout", 0, 0, 1);
    chk("timeout_lat", 32'(fe_cyc - t_fall), 32'(2 + FILTER_LEN + LIMIT));

    // Short low glitch in IDLE, then 0xF0.
    ps2_clk = 1'b0;
    wait_cyc(2);
    ps2_clk = 1'b1;
    wait_cyc(50);
    send_bits(mk_frame(8'hF0, 1'b1, 1'b1), 11, 125);
    wait_cyc(300);
    exp_data = 8'hF0;
    expect_frame("glitch_f0", 1, 0, 0);

    // Back-to-back 0xE0 and 0x75.
    send_bits(mk_frame(8'hE0, 1'b0, 1'b1), 11, 125);
    send_bits(mk_frame(8'h75, 1'b0, 1'b1), 11, 125);
    wait_cyc(300);
    chk("b2b_first", {24'h0, dv_log[s_dv % 64]}, 32'hE0);
    exp_data = 8'h75;
    expect_frame("b2b", 2, 0, 0);

    // Reset after the 4th data bit, then a full 0x1C frame.
    send_bits(mk_frame(8'hAA, 1'b1, 1'b1), 5, 125);
    rst_n = 1'b0;
    wait_cyc(3);
    chk("midrst_data", {24'h0, data}, 32'h0);
    rst_n = 1'b1;
    wait_cyc(20);
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11, 125);
    wait_cyc(300);
    exp_data = 8'h1C;
    expect_frame("midrst_1c", 1, 0, 0);

    // Random frames with occasional bad parity or stop bit.
    for (int k = 0; k < 8; k++) begin
      rb    = 8'($urandom);
      rpar  = 1'($urandom);
      rstop = ($urandom_range(0, 4) != 0);
      ones  = $countones(rb) + int'(rpar);
      edv = 0; epe = 0; efe = 0;
      if (!rstop) efe = 1;
      else if ((ones % 2) != 1) epe = 1;
      else begin
        edv = 1;
        exp_data = rb;
      end
      send_bits(mk_frame(rb, rpar, rstop), 11, 60);
      wait_cyc(150);
      expect_frame($sformatf("rnd%0d", k), edv, epe, efe);
    end

    chk("one_hot_status", 32'(n_multi), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
